// File: rtl/mov_rs_pkg.sv
// Shared types for the reservation stations: CDB broadcast and source-operand records.
package mov_rs_pkg;
  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } rs_opd_t;
endpackage

// File: rtl/rs_wakeup.sv
// Combinational operand wakeup: a waiting operand captures data from the
// lowest-numbered CDB whose tag matches.
module rs_wakeup
  import mov_rs_pkg::*;
#(
  parameter int N_CDB = 2
) (
  input  rs_opd_t              opd_in,
  input  cdb_t [N_CDB-1:0]     cdb,
  output rs_opd_t              opd_out
);

  always_comb begin
    opd_out = opd_in;
    if (!opd_in.valid) begin
      // scan high to low so the lowest matching bus is the last writer
      for (int i = N_CDB - 1; i >= 0; i--) begin
        if (cdb[i].valid && cdb[i].tag == opd_in.tag) begin
          opd_out.valid = 1'b1;
          opd_out.data  = cdb[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/mov_rs.sv
// Reservation station for register moves / immediate loads: compacted
// oldest-first queue, CDB wakeup, issue bypass and a registered output.
module mov_rs
  import mov_rs_pkg::*;
#(
  parameter int N_ENTRY = 4,
  parameter int N_CDB   = 2,
  parameter int C_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [ROB_WIDTH-1:0]             issue_tag,
  input  logic                             issue_imm_sel,
  input  logic [C_WIDTH-1:0]               issue_imm,
  input  logic                             opd_valid,
  input  logic [ROB_WIDTH-1:0]             opd_tag,
  input  logic [31:0]                      opd_data,
  input  logic [N_CDB-1:0]                 cdb_valid,
  input  logic [N_CDB-1:0][ROB_WIDTH-1:0]  cdb_tag,
  input  logic [N_CDB-1:0][31:0]           cdb_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROB_WIDTH-1:0]             out_tag,
  output logic [31:0]                      out_data
);

  localparam int CNT_W = $clog2(N_ENTRY + 1);
  localparam int IDX_W = $clog2(N_ENTRY);

  logic [N_ENTRY-1:0]                ent_vld;
  logic [N_ENTRY-1:0][ROB_WIDTH-1:0] ent_tag;
  rs_opd_t [N_ENTRY-1:0]             ent_opd;
  logic [CNT_W-1:0]                  count;

  cdb_t [N_CDB-1:0]                  cdb;
  rs_opd_t [N_ENTRY-1:0]             wk_opd;
  rs_opd_t                           inc_raw, inc_opd;

  // view carries one spare invalid slot on top so the shift-down reads in range
  logic [N_ENTRY:0]                  view_vld;
  logic [N_ENTRY:0][ROB_WIDTH-1:0]   view_tag;
  rs_opd_t [N_ENTRY:0]               view_opd;

  logic [N_ENTRY-1:0]                nxt_vld;
  logic [N_ENTRY-1:0][ROB_WIDTH-1:0] nxt_tag;
  rs_opd_t [N_ENTRY-1:0]             nxt_opd;

  logic                              sel_found;
  logic [IDX_W-1:0]                  sel_idx;
  logic [ROB_WIDTH-1:0]              sel_tag;
  logic [31:0]                       sel_data;
  logic                              accept, dispatch;
  logic [CNT_W-1:0]                  count_nxt;

  assign issue_ready = (count < CNT_W'(N_ENTRY));
  assign accept      = issue_valid && issue_ready && !flush;

  for (genvar c = 0; c < N_CDB; c++) begin : g_cdb
    assign cdb[c] = '{valid: cdb_valid[c], tag: cdb_tag[c], data: cdb_data[c]};
  end

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_wk
    rs_wakeup #(.N_CDB(N_CDB)) u_wk (
      .opd_in  (ent_opd[g]),
      .cdb     (cdb),
      .opd_out (wk_opd[g])
    );
  end

  always_comb begin
    inc_raw = '{valid: opd_valid, tag: opd_tag, data: opd_data};
    if (issue_imm_sel) inc_raw = '{valid: 1'b1, tag: '0, data: 32'($signed(issue_imm))};
  end

  rs_wakeup #(.N_CDB(N_CDB)) u_wk_inc (
    .opd_in  (inc_raw),
    .cdb     (cdb),
    .opd_out (inc_opd)
  );

  always_comb begin
    view_vld = {1'b0, ent_vld};
    view_tag = {{ROB_WIDTH{1'b0}}, ent_tag};
    view_opd = {rs_opd_t'('0), wk_opd};
    for (int i = 0; i < N_ENTRY; i++) begin
      if (accept && CNT_W'(i) == count) begin
        view_vld[i] = 1'b1;
        view_tag[i] = issue_tag;
        view_opd[i] = inc_opd;
      end
    end
  end

  // oldest-ready select
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!sel_found && view_vld[i] && view_opd[i].valid) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_tag   = view_tag[i];
        sel_data  = view_opd[i].data;
      end
    end
  end

  assign dispatch  = sel_found && !flush && (!out_valid || out_ready);
  assign count_nxt = count + CNT_W'(accept) - CNT_W'(dispatch);

  always_comb begin
    nxt_vld = view_vld[N_ENTRY-1:0];
    nxt_tag = view_tag[N_ENTRY-1:0];
    nxt_opd = view_opd[N_ENTRY-1:0];
    if (dispatch) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          nxt_vld[i] = view_vld[i+1];
          nxt_tag[i] = view_tag[i+1];
          nxt_opd[i] = view_opd[i+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld   <= '0;
      ent_tag   <= '0;
      ent_opd   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (flush) begin
      ent_vld   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      ent_vld <= nxt_vld;
      ent_tag <= nxt_tag;
      ent_opd <= nxt_opd;
      count   <= count_nxt;
      if (dispatch) begin
        out_valid <= 1'b1;
        out_tag   <= sel_tag;
        out_data  <= sel_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mov_rs.md
# mov_rs

Parametrised reservation station for register-move and immediate-load instructions in the out-of-order core. It sits between the issue stage and a GPR common-data-bus (CDB) writer port, and holds up to N_ENTRY waiting moves. Each entry snoops N_CDB result buses for its source operand. Ready entries dispatch oldest-first into a registered output with valid/ready handshake, and the whole station flushes on misprediction.

## Interface
- N_ENTRY, 4: station depth (≥2).
- N_CDB, 2: number of CDBs snooped (≥1).
- C_WIDTH, 16: immediate width, sign-extended to 32.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low; the only clock is clk.
- flush  input  1  synchronous discard of all entries and the output register.
- issue_valid  input  1  an instruction is offered.
- issue_ready  output  1  the station can accept (count < N_ENTRY).
- issue_tag  input  ROB_WIDTH  destination ROB tag.
- issue_imm_sel  input  1  1 = immediate move, operand taken from issue_imm.
- issue_imm  input  C_WIDTH  signed immediate.
- opd_valid  input  1  register operand already available.
- opd_tag  input  ROB_WIDTH  producer tag when opd_valid=0.
- opd_data  input  32  operand value when opd_valid=1.
- cdb_valid  input  N_CDB  per-bus broadcast valid.
- cdb_tag  input  N_CDB×ROB_WIDTH  broadcast tags.
- cdb_data  input  N_CDB×32  broadcast data.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  CDB arbiter accepts the result.
- out_tag  output  ROB_WIDTH  result ROB tag.
- out_data  output  32  result value.

## Operation
- Entries are stored compacted, index 0 oldest. count = number of valid entries.
- Each entry holds valid, tag, opd{valid, tag, data}.
- Wakeup: an entry with opd.valid=0 matches bus i when cdb_valid[i] && cdb_tag[i]==opd.tag. The entry takes cdb_data[i] and sets opd.valid. If several buses match the same tag, the lowest i wins.
- Incoming operand: if issue_imm_sel=1, it is the sign-extended issue_imm. Otherwise opd_data is used if opd_valid=1. Otherwise the current-cycle CDB is snooped, so a match at issue counts as ready.
- Updated view: each entry's state after this cycle's wakeup, with the incoming instruction appended at position count.
- Select: the lowest-index updated entry with operand ready, including the incoming instruction (bypass).
- Dispatch fires when a selectable entry exists, flush=0, and (!out_valid || out_ready). The selected entry loads the output register, entries above it shift down by one, and the incoming instruction is appended after the shift.
- An accept occurs on issue_valid && issue_ready. issue_ready depends only on registered count, with no combinational path from issue_valid or out_ready.
- Output register: loads on dispatch and clears on out_valid && out_ready with no new dispatch. It holds while out_valid && !out_ready.
- Flush: next cycle all entries are invalid, count=0, out_valid=0, and any issue in the flush cycle is dropped. Flush has priority over issue, dispatch and wakeup.
- Reset (async, reset=0): all entries invalid, count=0, out_valid=0, out_tag=0, out_data=0. issue_ready=1 as soon as reset deasserts.

## Timing
- Bypass latency: an issue at cycle t with a ready operand, an empty station and a free output appears as out_valid at t+1.
- Wakeup latency: a CDB match at t on a waiting entry allows dispatch at t, so out_valid rises at t+1.
- Throughput: 1 dispatch/cycle while out_ready=1.
- Full station (count=N_ENTRY): issue_ready=0 even if a dispatch occurs in that cycle.
- Simultaneous dispatch and accept keep count unchanged.
- Reset mid-operation discards everything immediately and asynchronously.

## Structure
- Shared package holds ROB_WIDTH, cdb_t {valid, tag, data}, and rs_opd_t {valid, tag, data}.
- Sub-module rs_wakeup: combinational operand update from one rs_opd_t plus N_CDB buses. It is instantiated per entry and once for the incoming operand, and is reusable by the ALU/FPU stations.
- Oldest-ready select is a priority loop inside mov_rs.

## Test plan
- Reset, then issue imm=-1 (issue_imm_sel=1) with out_ready=1 -> out_valid at t+1, out_data=32'hFFFFFFFF, issue_ready=1 throughout.
- Fill 4 entries waiting on tags 5,6,7,8; broadcast tag 7 on cdb[1] with data 0x77 -> third-oldest dispatches, out_tag and out_data=0x77 next cycle, count=3, remaining order 5,6,8.
- cdb[0] and cdb[1] both carry tag 5 (data 0xA, 0xB) while an entry waits on 5 -> captured data=0xA.
- Hold out_ready=0 with two ready entries -> the output holds the first result. Release -> back-to-back results on consecutive cycles, oldest first.
- Station full with a ready entry, out_ready=1, issue_valid=1 -> issue_ready=0 and the issue is not accepted. The next cycle issue_ready=1.
- Assert flush with 3 entries and out_valid=1 plus a concurrent issue -> next cycle out_valid=0, count=0, the issued instruction is never output. Async reset pulse mid-stream gives the same result immediately.
